// File: rtl/bus_server_pkg.sv
// Shared types and constants for the instruction-bus server: bus ops, access
// sizes, FSM states and the byte-count helper.
package bus_server_pkg;

    localparam int REG_DATAW = 64;
    localparam int REG_ADDRW = 5;
    localparam int RAM_ADDRW = 12;

    typedef enum logic [1:0] {
        BUS_NOP   = 2'd0,
        BUS_FETCH = 2'd1,
        BUS_STORE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        DT_BYTE = 2'd0,
        DT_WORD = 2'd1,
        DT_LONG = 2'd2,
        DT_QUAD = 2'd3
    } data_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_LOAD_LAST,
        ST_WB,
        ST_ERR
    } state_t;

    function automatic logic [3:0] byte_count(data_type_t dt);
        return 4'd1 << dt;
    endfunction

endpackage

// File: rtl/bus_byte_shifter.sv
// Byte shifter shared by both directions: parallel load then MSB-first shift-out
// for stores, shift-in accumulate for fetches.
module bus_byte_shifter #(
    parameter int W = bus_server_pkg::REG_DATAW
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic [3:0]   nbytes_i,
    input  logic         shift_i,
    input  logic [7:0]   shift_in_i,
    output logic [7:0]   byte_o,
    output logic [W-1:0] acc_o
);

    localparam int NB = W / 8;

    logic [W-1:0] sh_q, sh_d;
    logic [3:0]   pad_bytes;

    // A load left-justifies the n low bytes so the top byte is always the next to go out.
    always_comb begin
        pad_bytes = 4'(NB) - nbytes_i;
        sh_d      = sh_q;
        if (load_i) begin
            sh_d = load_data_i << {pad_bytes, 3'b000};
        end else if (shift_i) begin
            sh_d = {sh_q[W-9:0], shift_in_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign byte_o = sh_q[W-1 -: 8];
    assign acc_o  = sh_q;

endmodule

// File: rtl/bus_server.sv
// Server end of the instruction bus: executes big-endian 1/2/4/8-byte loads and
// stores over a byte-wide synchronous RAM port and writes fetches back.
module bus_server #(
    parameter int REG_DATAW = bus_server_pkg::REG_DATAW,
    parameter int REG_ADDRW = bus_server_pkg::REG_ADDRW,
    parameter int RAM_ADDRW = bus_server_pkg::RAM_ADDRW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           bus_op_i,
    input  logic [1:0]           bus_data_type_i,
    input  logic [REG_ADDRW-1:0] bus_data_reg_i,
    input  logic [REG_ADDRW-1:0] bus_addr_reg_i,
    input  logic [RAM_ADDRW-1:0] bus_addr_offset_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [REG_ADDRW-1:0] reg_a_addr_o,
    input  logic [REG_DATAW-1:0] reg_a_data_i,
    output logic [REG_ADDRW-1:0] reg_b_addr_o,
    input  logic [REG_DATAW-1:0] reg_b_data_i,
    output logic                 reg_we_o,
    output logic [REG_ADDRW-1:0] reg_waddr_o,
    output logic [REG_DATAW-1:0] reg_wdata_o,
    output logic [RAM_ADDRW-1:0] ram_addr_o,
    output logic                 ram_we_o,
    output logic [7:0]           ram_wdata_o,
    input  logic [7:0]           ram_rdata_i
);

    import bus_server_pkg::*;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [RAM_ADDRW-1:0] addr_q, addr_d;
    logic [REG_ADDRW-1:0] dreg_q, dreg_d;
    logic                 rd_pend_q, rd_pend_d;

    logic                 start, is_store, misaligned;
    logic [RAM_ADDRW-1:0] ea;
    logic [3:0]           nbytes;
    logic [2:0]           align_mask;
    logic                 sh_load, sh_shift;
    logic [REG_DATAW-1:0] sh_load_data, acc;
    logic [7:0]           out_byte;
    logic                 unused_base_hi;

    assign reg_a_addr_o   = bus_addr_reg_i;
    assign reg_b_addr_o   = bus_data_reg_i;
    assign unused_base_hi = ^reg_a_data_i[REG_DATAW-1:RAM_ADDRW];

    always_comb begin
        is_store   = (bus_op_i == BUS_STORE);
        start      = is_store || (bus_op_i == BUS_FETCH);
        nbytes     = byte_count(data_type_t'(bus_data_type_i));
        ea         = reg_a_data_i[RAM_ADDRW-1:0] + bus_addr_offset_i;
        align_mask = 3'(nbytes - 4'd1);
        misaligned = |(ea[2:0] & align_mask);
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        dreg_d       = dreg_q;
        rd_pend_d    = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_shift     = rd_pend_q;
        busy_o       = (state_q != ST_IDLE);
        done_o       = 1'b0;
        err_o        = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        reg_we_o     = 1'b0;
        reg_waddr_o  = '0;
        reg_wdata_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_load      = 1'b1;
                    sh_load_data = is_store ? reg_b_data_i : '0;
                    cnt_d        = nbytes;
                    addr_d       = ea;
                    dreg_d       = bus_data_reg_i;
                    state_d      = misaligned ? ST_ERR : (is_store ? ST_STORE : ST_LOAD);
                end
            end
            ST_STORE: begin
                ram_we_o    = 1'b1;
                ram_addr_o  = addr_q;
                ram_wdata_o = out_byte;
                sh_shift    = 1'b1;
                addr_d      = addr_q + RAM_ADDRW'(1);
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Read data returns one cycle later, so shift-in trails issue by one cycle.
                ram_addr_o = addr_q;
                rd_pend_d  = 1'b1;
                addr_d     = addr_q + RAM_ADDRW'(1);
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_LOAD_LAST;
                end
            end
            ST_LOAD_LAST: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                done_o      = 1'b1;
                reg_we_o    = (dreg_q != '0);
                reg_waddr_o = dreg_q;
                reg_wdata_o = acc;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                done_o  = 1'b1;
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dreg_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dreg_q    <= dreg_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    bus_byte_shifter #(.W(REG_DATAW)) u_shifter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (sh_load),
        .load_data_i (sh_load_data),
        .nbytes_i    (cnt_d),
        .shift_i     (sh_shift),
        .shift_in_i  (ram_rdata_i),
        .byte_o      (out_byte),
        .acc_o       (acc)
    );

endmodule

// File: tb/tb_bus_server.sv
// Self-checking bench for bus_server: a cycle-trace model built from the op rules
// is compared against the DUT every cycle, plus literal checks on RAM and write-back.
module tb_bus_server;

    localparam int AW = 12;
    localparam int RW = 5;
    localparam int DW = 64;
    localparam int MAXC = 4096;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_FETCH = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] DT_B = 2'd0, DT_W = 2'd1, DT_L = 2'd2, DT_Q = 2'd3;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic          ram_we;
        logic          rd;
        logic [AW-1:0] addr;
        logic [7:0]    wbyte;
        logic          reg_we;
        logic [RW-1:0] waddr;
        logic [DW-1:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, mem_clr, chk_en;
    logic [1:0]    bus_op, bus_dt;
    logic [RW-1:0] bus_dreg, bus_areg;
    logic [AW-1:0] bus_off;
    logic          busy, done, err, reg_we, ram_we;
    logic [RW-1:0] reg_a_addr, reg_b_addr, reg_waddr;
    logic [DW-1:0] reg_a_data, reg_b_data, reg_wdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;

    logic [DW-1:0] rf [0:31];
    logic [7:0]    mem [0:MAXC-1];
    logic [7:0]    ref_mem [0:MAXC-1];
    exp_t          exp_q [0:MAXC-1];

    int cyc = 0;
    int free_cyc, n_cmp, n_err, done_cnt, err_cnt, wb_cnt;
    logic [RW-1:0] last_waddr;
    logic [DW-1:0] last_wdata;

    assign reg_a_data = rf[reg_a_addr];
    assign reg_b_data = rf[reg_b_addr];

    bus_server dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus_op_i          (bus_op),
        .bus_data_type_i   (bus_dt),
        .bus_data_reg_i    (bus_dreg),
        .bus_addr_reg_i    (bus_areg),
        .bus_addr_offset_i (bus_off),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err),
        .reg_a_addr_o      (reg_a_addr),
        .reg_a_data_i      (reg_a_data),
        .reg_b_addr_o      (reg_b_addr),
        .reg_b_data_i      (reg_b_data),
        .reg_we_o          (reg_we),
        .reg_waddr_o       (reg_waddr),
        .reg_wdata_o       (reg_wdata),
        .ram_addr_o        (ram_addr),
        .ram_we_o          (ram_we),
        .ram_wdata_o       (ram_wdata),
        .ram_rdata_i       (ram_rdata)
    );

    // Byte-wide synchronous RAM, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MAXC; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Expected per-cycle trace of an op accepted in cycle t.
    task automatic schedule(input int t);
        int            nb;
        logic [AW-1:0] ea;
        logic [DW-1:0] d, acc;
        exp_t          e;
        nb = 1 << bus_dt;
        ea = rf[bus_areg][AW-1:0] + bus_off;
        d  = rf[bus_dreg];
        if ((int'(ea) % nb) != 0) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            exp_q[t+1] = e;
            free_cyc = t + 2;
        end else if (bus_op == OP_STORE) begin
            for (int i = 1; i <= nb; i++) begin
                e = '0; e.busy = 1'b1; e.ram_we = 1'b1;
                e.addr  = ea + AW'(i - 1);
                e.wbyte = 8'(d >> (8 * (nb - i)));
                e.done  = (i == nb);
                exp_q[t+i] = e;
            end
            free_cyc = t + nb + 1;
        end else begin
            acc = '0;
            for (int i = 1; i <= nb; i++) begin
                e = '0; e.busy = 1'b1; e.rd = 1'b1;
                e.addr = ea + AW'(i - 1);
                acc = (acc << 8) | DW'(ref_mem[e.addr]);
                exp_q[t+i] = e;
            end
            e = '0; e.busy = 1'b1;
            exp_q[t+nb+1] = e;
            e.done = 1'b1; e.reg_we = (bus_dreg != '0); e.waddr = bus_dreg; e.wdata = acc;
            exp_q[t+nb+2] = e;
            free_cyc = t + nb + 3;
        end
    endtask

    // Model + compare process, evaluated mid-cycle when DUT outputs and bench inputs are stable.
    initial begin : model
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_clr) begin
                for (int i = 0; i < MAXC; i++) begin
                    ref_mem[i] = 8'h00;
                    exp_q[i]   = '0;
                end
                free_cyc = 0;
            end else begin
                e = exp_q[cyc];
                if (chk_en) begin
                    check("busy",   64'(busy),   64'(e.busy));
                    check("done",   64'(done),   64'(e.done));
                    check("err",    64'(err),    64'(e.err));
                    check("ram_we", 64'(ram_we), 64'(e.ram_we));
                    check("reg_we", 64'(reg_we), 64'(e.reg_we));
                    if (e.ram_we || e.rd) check("ram_addr", 64'(ram_addr), 64'(e.addr));
                    if (e.ram_we) check("ram_wdata", 64'(ram_wdata), 64'(e.wbyte));
                    if (e.reg_we) begin
                        check("reg_waddr", 64'(reg_waddr), 64'(e.waddr));
                        check("reg_wdata", reg_wdata, e.wdata);
                    end
                end
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (reg_we) begin
                    wb_cnt++;
                    last_waddr = reg_waddr;
                    last_wdata = reg_wdata;
                end
                if (e.ram_we) ref_mem[e.addr] = e.wbyte;
                if (rst) begin
                    for (int k = 1; k <= 12; k++) exp_q[cyc+k] = '0;
                    free_cyc = cyc + 1;
                end else if (cyc >= free_cyc && (bus_op == OP_FETCH || bus_op == OP_STORE)) begin
                    schedule(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] dt, input int dr, input int ar,
                         input int off);
        bus_op   = op;
        bus_dt   = dt;
        bus_dreg = RW'(dr);
        bus_areg = RW'(ar);
        bus_off  = AW'(off);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && (busy || cyc < free_cyc); i++) tick();
        check("idle_wait", 64'(busy || cyc < free_cyc), 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] dt, input int dr, input int ar,
                         input int off);
        tick();
        drive(op, dt, dr, ar, off);
        tick();
        bus_op = OP_NOP;
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int d0, e0, w0;
        n_cmp = 0; n_err = 0; done_cnt = 0; err_cnt = 0; wb_cnt = 0;
        last_waddr = '0; last_wdata = '0;
        rst = 1'b1; mem_clr = 1'b1; chk_en = 1'b0;
        drive(OP_NOP, DT_B, 0, 0, 0);
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1]  = 64'h0000_0000_0000_0100;
        rf[2]  = 64'h0123_4567_89AB_CDEF;
        rf[3]  = 64'h0000_0000_0000_001E;
        rf[6]  = 64'h0000_0000_0000_0FFF;
        rf[7]  = 64'h0000_0000_0000_00A5;
        rf[8]  = 64'h0000_0000_0000_0200;
        rf[9]  = 64'h1122_3344_5566_7788;
        rf[10] = 64'h0000_0000_0000_BEEF;
        rf[13] = 64'h0000_0000_0000_CAFE;
        rf[14] = 64'h0000_0000_0000_0300;
        rf[17] = 64'hFFFF_0000_0000_0108;

        repeat (3) tick();
        mem_clr = 1'b0;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_done",   64'(done),      64'd0);
        check("rst_err",    64'(err),       64'd0);
        check("rst_ram_we", 64'(ram_we),    64'd0);
        check("rst_reg_we", 64'(reg_we),    64'd0);
        check("rst_raddr",  64'(ram_addr),  64'd0);
        check("rst_rwdata", 64'(ram_wdata), 64'd0);
        check("rst_waddr",  64'(reg_waddr), 64'd0);
        check("rst_wdata",  reg_wdata,      64'd0);

        // Quad store 0x0123456789ABCDEF to 0x108..0x10F.
        issue(OP_STORE, DT_Q, 2, 1, 8);
        check("mem_108", 64'(mem[12'h108]), 64'h01);
        check("mem_10b", 64'(mem[12'h10B]), 64'h67);
        check("mem_10f", 64'(mem[12'h10F]), 64'hEF);

        // Word store BE,EF at 0x20, then fetch it back into r5.
        issue(OP_STORE, DT_W, 10, 3, 2);
        issue(OP_FETCH, DT_W, 5, 3, 2);
        check("beef_waddr", 64'(last_waddr), 64'd5);
        check("beef_wdata", last_wdata, 64'h0000_0000_0000_BEEF);

        // Misaligned long store (ea 0x102) and misaligned quad fetch (ea 0x104).
        e0 = err_cnt; w0 = wb_cnt;
        issue(OP_STORE, DT_L, 2, 1, 2);
        issue(OP_FETCH, DT_Q, 5, 1, 4);
        check("misal_errs", 64'(err_cnt - e0), 64'd2);
        check("misal_wb",   64'(wb_cnt - w0),  64'd0);
        check("mem_102",    64'(mem[12'h102]), 64'h00);

        // Byte fetch into the zero register: done pulses, no write-back.
        d0 = done_cnt; w0 = wb_cnt;
        issue(OP_FETCH, DT_B, 0, 1, 8);
        check("r0_done", 64'(done_cnt - d0), 64'd1);
        check("r0_wb",   64'(wb_cnt - w0),   64'd0);

        // Address wrap: 0xFFF + 1 stores to address 0.
        issue(OP_STORE, DT_B, 7, 6, 1);
        check("wrap_mem0", 64'(mem[0]), 64'hA5);

        // Long fetch, and a base with high bits outside the RAM address range.
        issue(OP_FETCH, DT_L, 11, 1, 8);
        check("long_wdata", last_wdata, 64'h0000_0000_0123_4567);
        issue(OP_FETCH, DT_Q, 16, 17, 0);
        check("quad_wdata", last_wdata, 64'h0123_4567_89AB_CDEF);

        // Reset during cycle T+3 of a quad store at 0x200.
        tick();
        drive(OP_STORE, DT_Q, 9, 8, 0);
        tick();
        bus_op = OP_NOP;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   64'(busy),   64'd0);
        check("abort_ram_we", 64'(ram_we), 64'd0);
        wait_idle();
        check("abort_202", 64'(mem[12'h202]), 64'h33);
        check("abort_203", 64'(mem[12'h203]), 64'h00);
        issue(OP_FETCH, DT_L, 12, 8, 0);
        check("post_rst_wdata", last_wdata, 64'h0000_0000_1122_3300);

        // Store op held across done: exactly two identical word stores.
        d0 = done_cnt;
        tick();
        drive(OP_STORE, DT_W, 13, 14, 0);
        repeat (4) tick();
        bus_op = OP_NOP;
        wait_idle();
        check("b2b_dones", 64'(done_cnt - d0), 64'd2);
        issue(OP_FETCH, DT_W, 15, 14, 0);
        check("b2b_wdata", last_wdata, 64'h0000_0000_0000_CAFE);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
